// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - two-requester round-robin immediate extender with a one-entry result register
module imm_ext_arbiter #(
    parameter int IMM_W  = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [IMM_W-1:0]  a_imm,
    input  logic [1:0]        a_mode,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [IMM_W-1:0]  b_imm,
    input  logic [1:0]        b_mode,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_id,
    output logic              resp_err
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state;
    logic             prio_b;
    logic             can_accept;
    logic             grant_a;
    logic             grant_b;
    logic [IMM_W-1:0] sel_imm;
    logic [1:0]       sel_mode;

    function automatic logic [DATA_W-1:0] extend(input logic [IMM_W-1:0] imm,
                                                 input logic [1:0] mode);
        logic [DATA_W-1:0] sext;
        logic [DATA_W-1:0] zext;
        sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        zext = {{(DATA_W-IMM_W){1'b0}}, imm};
        case (mode)
            2'b01:   extend = zext;
            2'b10:   extend = sext << 2;
            default: extend = sext;
        endcase
    endfunction

    // A pop in the same cycle frees the register, so FULL with resp_ready still accepts.
    assign can_accept = reset_n && ((state == ST_EMPTY) || resp_ready);
    assign grant_a    = can_accept && a_valid && (!b_valid || !prio_b);
    assign grant_b    = can_accept && b_valid && (!a_valid || prio_b);
    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign sel_imm    = grant_b ? b_imm : a_imm;
    assign sel_mode   = grant_b ? b_mode : a_mode;
    assign resp_valid = (state == ST_FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            prio_b    <= 1'b0;
            resp_data <= '0;
            resp_id   <= 1'b0;
            resp_err  <= 1'b0;
        end else if (grant_a || grant_b) begin
            state     <= ST_FULL;
            prio_b    <= grant_a;
            resp_data <= extend(sel_imm, sel_mode);
            resp_id   <= grant_b;
            resp_err  <= (sel_mode == 2'b11);
        end else if ((state == ST_FULL) && resp_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL have parameter IMM_W, default 14, immediate field width.
REQ-002 SHALL have parameter DATA_W, default 32, extended result width; DATA_W > IMM_W+2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 a_valid  input  1  requester A (branch unit) has a request.
REQ-006 a_ready  output  1  request A accepted this cycle.
REQ-007 a_imm  input  IMM_W  requester A immediate.
REQ-008 a_mode  input  2  requester A extension mode.
REQ-009 b_valid, b_ready, b_imm, b_mode SHALL mirror the A ports for requester B (load/store unit).
REQ-010 resp_valid  output  1  result register holds a result.
REQ-011 resp_ready  input  1  consumer accepts the result.
REQ-012 resp_data  output  DATA_W  extended immediate.
REQ-013 resp_id  output  1  0 = result for A, 1 = for B.
REQ-014 resp_err  output  1  request carried reserved mode 2'b11.

Function
REQ-015 Modes SHALL be: 00 sign-extend; 01 zero-extend; 10 sign-extend then shift left 2 (bits [1:0] = 0); 11 reserved, treated as 00 with resp_err = 1.
REQ-016 Sign-extend SHALL set resp_data[IMM_W-1:0] = imm and every bit [DATA_W-1:IMM_W] = imm[IMM_W-1].
REQ-017 Mode 10 SHALL produce (sign-extended imm) << 2, truncated to DATA_W.
REQ-018 FSM SHALL have two states: EMPTY (resp_valid = 0) and FULL (resp_valid = 1).
REQ-019 A request SHALL be accepted when in EMPTY, or in FULL with resp_ready = 1 (same-cycle pop and push).
REQ-020 At most one requester SHALL be accepted per cycle; a_ready and b_ready SHALL never both be 1.
REQ-021 a_ready/b_ready SHALL be combinational from valids, FSM state, resp_ready and the priority pointer; never dependent on a ready.
REQ-022 Only one valid: that requester is granted if acceptance allowed.
REQ-023 Both valid: round-robin; grant the requester not granted last; pointer after reset favours A.
REQ-024 Priority pointer SHALL update only on an accepted grant.
REQ-025 Latency SHALL be 1 cycle: request accepted at edge N appears on resp_* after edge N, held stable until resp_ready = 1.
REQ-026 FULL with resp_ready = 1 and no accepted request -> EMPTY; with accepted request -> stay FULL with new result.
REQ-027 FULL with resp_ready = 0 -> hold resp_data/resp_id/resp_err unchanged; both readies 0.
REQ-028 A requester kept valid but not granted SHALL be granted no later than the second acceptance opportunity (no starvation).
REQ-029 resp_data, resp_id, resp_err SHALL be registered outputs, don't-care content only when resp_valid = 0 but SHALL retain last value.

Reset
REQ-030 reset_n low SHALL immediately force EMPTY, resp_valid = 0, resp_data = 0, resp_id = 0, resp_err = 0, pointer = favour A.
REQ-031 Reset asserted mid-operation SHALL discard any held result; no response SHALL appear after deassertion without a new acceptance.
REQ-032 a_ready and b_ready SHALL be 0 while reset_n is low.

Verification
REQ-033 A only, a_imm=14'h2000, mode 00, resp_ready=1 -> next cycle resp_valid=1, resp_data=32'hFFFF_E000, resp_id=0.
REQ-034 B only, b_imm=14'h3FFF, mode 01 -> resp_data=32'h0000_3FFF; mode 10 with b_imm=14'h3FFF -> 32'hFFFF_FFFC, resp_id=1.
REQ-035 Both valid for 4 accepted cycles, resp_ready=1 -> grants A,B,A,B; resp_id 0,1,0,1 back-to-back with no bubble.
REQ-036 resp_ready=0 for 3 cycles while FULL, both valid -> readies 0, resp_* stable; on resp_ready=1 the next requester is accepted same cycle.
REQ-037 a_mode=11, a_imm=14'h0001 -> resp_data=32'h0000_0001, resp_err=1.
REQ-038 reset_n pulsed low while FULL -> resp_valid drops asynchronously, all outputs 0, first grant after release goes to A when both valid.
